// File: rtl/ctrl_encode_def_pkg.sv
// ctrl_encode_def -- shared control encodings used by the fetch/execute
// redirect logic.
//   NPC type (carried down with each instruction):
//     NPC_PLUS4  sequential, NPC_BRANCH conditional branch, NPC_JUMP jump.
//     The fourth code is unused and treated like NPC_PLUS4.
//   next_sel (selects the next fetch PC):
//     NSEL_FETCH   follow the fetch stage's own choice
//     NSEL_PRED_OK prediction was right, keep going
//     NSEL_PC4     redirect to ex_pc + 4
//     NSEL_TARGET  redirect to the branch/jump target
package ctrl_encode_def;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [1:0] NSEL_FETCH   = 2'b00;
    localparam logic [1:0] NSEL_PRED_OK = 2'b01;
    localparam logic [1:0] NSEL_PC4     = 2'b10;
    localparam logic [1:0] NSEL_TARGET  = 2'b11;

    // 2-bit saturating counter states
    localparam logic [1:0] CNT_STRONG_NT = 2'b00;
    localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
    localparam logic [1:0] CNT_WEAK_T    = 2'b10;
    localparam logic [1:0] CNT_STRONG_T  = 2'b11;

endpackage

// File: rtl/sat_counter2.sv
// sat_counter2 -- next-state function of a 2-bit saturating counter.
//   cnt      in  2  current counter value
//   taken    in  1  outcome: 1 counts up, 0 counts down
//   cnt_next out 2  updated value, clamped to 00..11
module sat_counter2
    import ctrl_encode_def::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_STRONG_T)
                cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != CNT_STRONG_NT)
                cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit -- bimodal branch predictor with EX-stage resolution.
//   clk, rst        clock, synchronous active-high reset
//   if_pc           fetch PC to predict
//   pred_taken      prediction for if_pc (combinational, from the table)
//   ex_valid/stall  EX stage occupancy / freeze
//   ex_npctype      NPC type of the EX instruction
//   ex_zero         branch actually taken
//   ex_pc           PC of the EX instruction (selects the entry to train)
//   ex_pred_taken   prediction that travelled with the EX instruction
//   next_sel, flush redirect decision (combinational)
//   branch_cnt      resolved branches, saturating
//   mispred_cnt     mispredicted branches, saturating
module branch_predict_unit
    import ctrl_encode_def::*;
#(
    parameter int IDX_W  = 6,
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [1:0]        ex_npctype,
    input  logic              ex_zero,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    output logic [1:0]        next_sel,
    output logic              flush,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    // Flop array so that a single reset cycle clears every entry.
    logic [1:0] bht [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_cur;
    logic [1:0]       wr_next;
    logic             resolve;
    logic             is_branch;

    assign rd_idx  = if_pc[IDX_W+1:2];
    assign wr_idx  = ex_pc[IDX_W+1:2];
    assign wr_cur  = bht[wr_idx];

    // Read straight from the array: a same-cycle update to this index is
    // not bypassed, the new value shows up one cycle later.
    assign pred_taken = bht[rd_idx][1];

    assign resolve   = ex_valid && !ex_stall;
    assign is_branch = resolve && (ex_npctype == NPC_BRANCH);

    always_comb begin
        next_sel = NSEL_FETCH;
        flush    = 1'b0;
        if (resolve) begin
            case (ex_npctype)
                NPC_BRANCH: begin
                    if (ex_zero == ex_pred_taken) begin
                        next_sel = NSEL_PRED_OK;
                    end else if (ex_zero) begin
                        next_sel = NSEL_TARGET;
                        flush    = 1'b1;
                    end else begin
                        next_sel = NSEL_PC4;
                        flush    = 1'b1;
                    end
                end
                NPC_JUMP: begin
                    next_sel = NSEL_TARGET;
                    flush    = 1'b1;
                end
                default: begin
                    next_sel = NSEL_FETCH;
                    flush    = 1'b0;
                end
            endcase
        end
    end

    sat_counter2 u_sat (
        .cnt      (wr_cur),
        .taken    (ex_zero),
        .cnt_next (wr_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                bht[i] <= CNT_WEAK_NT;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (is_branch) begin
            bht[wr_idx] <= wr_next;
            if (branch_cnt != {STAT_W{1'b1}})
                branch_cnt <= branch_cnt + 1'b1;
            // On a branch, flush is exactly the misprediction condition.
            if (flush && (mispred_cnt != {STAT_W{1'b1}}))
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule
